// File: rtl/goose_pkg.sv
// Shared definitions for the goose sprite path: pose encoding, motion states
// and the ground row used by both the motion controller and the sprite blocks.
package goose_pkg;

  localparam logic [9:0] GROUND_Y = 10'd380;

  localparam logic [1:0] POSE_RUN_A = 2'd0;
  localparam logic [1:0] POSE_RUN_B = 2'd1;
  localparam logic [1:0] POSE_JUMP  = 2'd2;
  localparam logic [1:0] POSE_SLIDE = 2'd3;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_JUMP  = 2'd1,
    ST_SLIDE = 2'd2
  } state_t;

endpackage

// File: rtl/goose_motion.sv
// Per-frame goose motion controller: turns jump/slide buttons into the sprite
// anchor row and pose, advancing only on unfrozen frame ticks.
module goose_motion
  import goose_pkg::*;
#(
  parameter int unsigned JUMP_V0     = 12,
  parameter int unsigned GRAVITY     = 1,
  parameter int unsigned ANIM_FRAMES = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic       btn_jump,
  input  logic       btn_slide,
  input  logic       freeze,
  input  logic       restart,
  output logic [9:0] goose_y,
  output logic [1:0] pose,
  output logic       airborne
);

  localparam int CNT_W = (ANIM_FRAMES > 1) ? $clog2(ANIM_FRAMES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ANIM_FRAMES - 1);
  localparam logic [7:0]        V0_8    = 8'(JUMP_V0);
  localparam logic signed [7:0] GRAV_8  = 8'(GRAVITY);
  localparam logic signed [9:0] GRAV_10 = 10'(GRAVITY);

  state_t                state_r, state_nxt_s;
  logic [7:0]            height_r, height_nxt_s;
  logic signed [7:0]     vel_r, vel_nxt_s;
  logic [CNT_W-1:0]      anim_cnt_r, anim_nxt_s;
  logic                  run_b_r, run_b_nxt_s;
  logic                  jump_req_r, btn_jump_d_r;
  logic [9:0]            goose_y_r, goose_y_nxt_s;
  logic [1:0]            pose_r, pose_nxt_s;
  logic                  airborne_r, airborne_nxt_s;

  logic                  jump_edge_s, jump_seen_s, update_s;
  logic signed [9:0]     height_ext_s, vel_ext_s, fall_s;

  assign jump_edge_s  = btn_jump & ~btn_jump_d_r;
  // an edge arriving with the tick itself must still launch the jump
  assign jump_seen_s  = jump_req_r | jump_edge_s;
  assign update_s     = frame_tick & ~freeze;
  assign height_ext_s = {2'b00, height_r};
  assign vel_ext_s    = {{2{vel_r[7]}}, vel_r};
  assign fall_s       = height_ext_s + vel_ext_s - GRAV_10;

  // Next-state logic for the RUN/JUMP/SLIDE machine and its datapath.
  always_comb begin
    state_nxt_s  = state_r;
    height_nxt_s = height_r;
    vel_nxt_s    = vel_r;
    anim_nxt_s   = anim_cnt_r;
    run_b_nxt_s  = run_b_r;
    case (state_r)
      ST_RUN: begin
        if (jump_seen_s) begin
          state_nxt_s  = ST_JUMP;
          height_nxt_s = V0_8;
          vel_nxt_s    = signed'(V0_8);
        end else if (btn_slide) begin
          state_nxt_s = ST_SLIDE;
        end else if (anim_cnt_r == CNT_LAST) begin
          anim_nxt_s  = {CNT_W{1'b0}};
          run_b_nxt_s = ~run_b_r;
        end else begin
          anim_nxt_s = anim_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      ST_JUMP: begin
        if (fall_s <= 10'sd0) begin
          state_nxt_s  = ST_RUN;
          height_nxt_s = 8'd0;
          vel_nxt_s    = 8'sd0;
          anim_nxt_s   = {CNT_W{1'b0}};
          run_b_nxt_s  = 1'b0;
        end else begin
          height_nxt_s = fall_s[7:0];
          vel_nxt_s    = vel_r - GRAV_8;
        end
      end
      ST_SLIDE: begin
        if (jump_seen_s) begin
          state_nxt_s  = ST_JUMP;
          height_nxt_s = V0_8;
          vel_nxt_s    = signed'(V0_8);
        end else if (!btn_slide) begin
          state_nxt_s = ST_RUN;
          anim_nxt_s  = {CNT_W{1'b0}};
          run_b_nxt_s = 1'b0;
        end else begin
          state_nxt_s = ST_SLIDE;
        end
      end
      default: begin
        state_nxt_s  = ST_RUN;
        height_nxt_s = 8'd0;
        vel_nxt_s    = 8'sd0;
        anim_nxt_s   = {CNT_W{1'b0}};
        run_b_nxt_s  = 1'b0;
      end
    endcase
  end

  // Output values derived from the next state, registered on the update edge.
  always_comb begin
    pose_nxt_s = POSE_RUN_A;
    case (state_nxt_s)
      ST_RUN:   pose_nxt_s = run_b_nxt_s ? POSE_RUN_B : POSE_RUN_A;
      ST_JUMP:  pose_nxt_s = POSE_JUMP;
      ST_SLIDE: pose_nxt_s = POSE_SLIDE;
      default:  pose_nxt_s = POSE_RUN_A;
    endcase
    airborne_nxt_s = (height_nxt_s != 8'd0) || (state_nxt_s == ST_JUMP);
    goose_y_nxt_s  = GROUND_Y - {2'b00, height_nxt_s};
  end

  // State, request latch, edge detector and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_RUN;
      height_r     <= 8'd0;
      vel_r        <= 8'sd0;
      anim_cnt_r   <= {CNT_W{1'b0}};
      run_b_r      <= 1'b0;
      jump_req_r   <= 1'b0;
      btn_jump_d_r <= 1'b0;
      goose_y_r    <= GROUND_Y;
      pose_r       <= POSE_RUN_A;
      airborne_r   <= 1'b0;
    end else if (restart) begin
      state_r      <= ST_RUN;
      height_r     <= 8'd0;
      vel_r        <= 8'sd0;
      anim_cnt_r   <= {CNT_W{1'b0}};
      run_b_r      <= 1'b0;
      jump_req_r   <= 1'b0;
      btn_jump_d_r <= 1'b0;
      goose_y_r    <= GROUND_Y;
      pose_r       <= POSE_RUN_A;
      airborne_r   <= 1'b0;
    end else if (update_s) begin
      state_r      <= state_nxt_s;
      height_r     <= height_nxt_s;
      vel_r        <= vel_nxt_s;
      anim_cnt_r   <= anim_nxt_s;
      run_b_r      <= run_b_nxt_s;
      jump_req_r   <= 1'b0;
      btn_jump_d_r <= btn_jump;
      goose_y_r    <= goose_y_nxt_s;
      pose_r       <= pose_nxt_s;
      airborne_r   <= airborne_nxt_s;
    end else if (!freeze) begin
      jump_req_r   <= jump_req_r | jump_edge_s;
      btn_jump_d_r <= btn_jump;
    end else begin
      jump_req_r   <= jump_req_r;
      btn_jump_d_r <= btn_jump_d_r;
    end
  end

  assign goose_y  = goose_y_r;
  assign pose     = pose_r;
  assign airborne = airborne_r;

endmodule

// File: tb/tb_goose_motion.sv
// Directed bench for goose_motion: run animation, jump arc, slide, freeze,
// restart and asynchronous reset, each scenario checked against hand values.
module tb_goose_motion;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       frame_tick = 1'b0;
  logic       btn_jump = 1'b0;
  logic       btn_slide = 1'b0;
  logic       freeze = 1'b0;
  logic       restart = 1'b0;
  logic [9:0] goose_y;
  logic [1:0] pose;
  logic       airborne;

  int total = 0;
  int bad   = 0;

  goose_motion dut (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .btn_jump(btn_jump),
    .btn_slide(btn_slide), .freeze(freeze), .restart(restart),
    .goose_y(goose_y), .pose(pose), .airborne(airborne)
  );

  always #5 clk = ~clk;

  // height after jump tick k with V0=12, gravity 1; zero once landed
  function automatic int jump_h(input int k);
    int h;
    h = 12 * k - (k * (k - 1)) / 2;
    if (h < 0) h = 0;
    return h;
  endfunction

  task automatic tick();
    @(negedge clk);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
  endtask

  task automatic tick_jump_edge();
    @(negedge clk);
    frame_tick = 1'b1;
    btn_jump   = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (goose_y !== 10'd380 || pose !== 2'd0 || airborne !== 1'b0) begin
      bad++;
      $display("FAIL reset: y=%0d pose=%0d air=%0b, want y=380 pose=0 air=0", goose_y, pose, airborne);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_run_anim();
    logic [1:0] exp_pose;
    for (int k = 1; k <= 20; k++) begin
      tick();
      exp_pose = ((k / 8) % 2 == 1) ? 2'd1 : 2'd0;
      total++;
      if (goose_y !== 10'd380 || pose !== exp_pose || airborne !== 1'b0) begin
        bad++;
        $display("FAIL run_anim tick %0d: y=%0d pose=%0d air=%0b, want y=380 pose=%0d air=0",
                 k, goose_y, pose, airborne, exp_pose);
      end
    end
  endtask

  task automatic test_jump_arc();
    logic [9:0] exp_y;
    logic [1:0] exp_pose;
    logic       exp_air;
    @(negedge clk) btn_jump = 1'b1;
    @(negedge clk) btn_jump = 1'b0;
    repeat (3) @(negedge clk);
    for (int k = 1; k <= 25; k++) begin
      tick();
      exp_y    = 10'(380 - jump_h(k));
      exp_pose = (k < 25) ? 2'd2 : 2'd0;
      exp_air  = (k < 25);
      total++;
      if (goose_y !== exp_y || pose !== exp_pose || airborne !== exp_air) begin
        bad++;
        $display("FAIL jump_arc tick %0d: y=%0d pose=%0d air=%0b, want y=%0d pose=%0d air=%0b",
                 k, goose_y, pose, airborne, exp_y, exp_pose, exp_air);
      end
      if (k == 1 || k == 2 || k == 3 || k == 12 || k == 13) begin
        total++;
        if (goose_y !== ((k == 1) ? 10'd368 : (k == 2) ? 10'd357 : (k == 3) ? 10'd347 : 10'd302)) begin
          bad++;
          $display("FAIL jump_key tick %0d: y=%0d", k, goose_y);
        end
      end
    end
  endtask

  task automatic test_same_tick_and_double_jump();
    logic [9:0] exp_y;
    tick_jump_edge();
    total++;
    if (pose !== 2'd2 || goose_y !== 10'd368) begin
      bad++;
      $display("FAIL same_tick_jump: y=%0d pose=%0d, want y=368 pose=2", goose_y, pose);
    end
    btn_jump = 1'b0;
    for (int k = 2; k <= 25; k++) begin
      if (k == 5) tick_jump_edge();
      else tick();
      btn_jump = 1'b0;
      if (k == 23) begin
        btn_jump = 1'b1;
        @(negedge clk) btn_jump = 1'b0;
      end
      exp_y = 10'(380 - jump_h(k));
      total++;
      if (goose_y !== exp_y || pose !== ((k < 25) ? 2'd2 : 2'd0)) begin
        bad++;
        $display("FAIL double_jump tick %0d: y=%0d pose=%0d, want y=%0d", k, goose_y, pose, exp_y);
      end
    end
    tick();
    total++;
    if (goose_y !== 10'd380 || pose !== 2'd0 || airborne !== 1'b0) begin
      bad++;
      $display("FAIL stale_req: y=%0d pose=%0d air=%0b, want y=380 pose=0 air=0", goose_y, pose, airborne);
    end
  endtask

  task automatic test_slide();
    btn_slide = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      total++;
      if (goose_y !== 10'd380 || pose !== 2'd3 || airborne !== 1'b0) begin
        bad++;
        $display("FAIL slide tick %0d: y=%0d pose=%0d air=%0b, want y=380 pose=3 air=0",
                 k, goose_y, pose, airborne);
      end
    end
    btn_slide = 1'b0;
    tick();
    total++;
    if (goose_y !== 10'd380 || pose !== 2'd0) begin
      bad++;
      $display("FAIL slide_release: y=%0d pose=%0d, want y=380 pose=0", goose_y, pose);
    end
  endtask

  task automatic test_jump_over_slide_freeze_restart();
    btn_slide = 1'b1;
    tick_jump_edge();
    total++;
    if (pose !== 2'd2 || goose_y !== 10'd368 || airborne !== 1'b1) begin
      bad++;
      $display("FAIL jump_over_slide: y=%0d pose=%0d air=%0b, want y=368 pose=2 air=1", goose_y, pose, airborne);
    end
    btn_jump  = 1'b0;
    btn_slide = 1'b0;
    for (int k = 2; k <= 10; k++) tick();
    freeze = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      tick();
      if (k == 5) begin
        btn_jump = 1'b1;
        @(negedge clk) btn_jump = 1'b0;
      end
      total++;
      if (goose_y !== 10'd305 || pose !== 2'd2 || airborne !== 1'b1) begin
        bad++;
        $display("FAIL freeze tick %0d: y=%0d pose=%0d air=%0b, want y=305 pose=2 air=1",
                 k, goose_y, pose, airborne);
      end
    end
    @(negedge clk) restart = 1'b1;
    @(negedge clk) restart = 1'b0;
    total++;
    if (goose_y !== 10'd380 || pose !== 2'd0 || airborne !== 1'b0) begin
      bad++;
      $display("FAIL restart: y=%0d pose=%0d air=%0b, want y=380 pose=0 air=0", goose_y, pose, airborne);
    end
    freeze = 1'b0;
  endtask

  task automatic test_async_reset();
    tick_jump_edge();
    btn_jump = 1'b0;
    for (int k = 2; k <= 6; k++) tick();
    total++;
    if (goose_y !== 10'd323) begin
      bad++;
      $display("FAIL pre_reset_height: y=%0d, want 323", goose_y);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (goose_y !== 10'd380 || pose !== 2'd0 || airborne !== 1'b0) begin
      bad++;
      $display("FAIL async_reset: y=%0d pose=%0d air=%0b, want y=380 pose=0 air=0", goose_y, pose, airborne);
    end
    @(negedge clk) rst_n = 1'b1;
    tick();
    total++;
    if (goose_y !== 10'd380 || pose !== 2'd0) begin
      bad++;
      $display("FAIL after_reset: y=%0d pose=%0d, want y=380 pose=0", goose_y, pose);
    end
  endtask

  initial begin
    test_reset();
    test_run_anim();
    test_jump_arc();
    test_same_tick_and_double_jump();
    test_slide();
    test_jump_over_slide_freeze_restart();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
